weight_pingpong_buf: RTL and testbench
======================================

# weight_pingpong_buf

Double-buffered (ping-pong) weight store between the weight bus interface unit and the MAC array. It captures the 160-word weight stream for one output channel: 144 words of 3x3 kernel and 16 words of 1x1 kernel, each word holding four int8 weights. While the MAC array reads one bank, the next output channel's weights fill the other bank. Bank ownership moves through a fill-done / release handshake.

## Interface
Parameters:
- DATA_W, 32, weight word width (four int8 weights).
- K3_WORDS, 144, 3x3 words per bank (9 kernel positions x 16 channel-words).
- K1_WORDS, 16, 1x1 words per bank.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- weight_waddr  input  32  write address: [31] 0=3x3 / 1=1x1; [30:23] output-channel tag; [11:6] kernel position 0..8 (ignored when [31]=1); [5:0] channel-word 0..15 (bits [5:4] ignored).
- weight_wdata  input  DATA_W  write data.
- weight_wen  input  1  write strobe, one word per cycle.
- weight_done  input  1  one-cycle pulse: current fill complete.
- fill_rdy  output  1  write bank is EMPTY; the controller may issue weight_start.
- wbuf_vld  output  1  read bank is FULL; the MAC array may read.
- wbuf_och  output  8  output-channel tag of the read bank.
- wbuf_release  input  1  one-cycle pulse: MAC array is finished with the read bank.
- rd_en  input  1  read request.
- rd_1x1  input  1  select the 1x1 region.
- rd_pos  input  4  kernel position 0..8 (ignored when rd_1x1=1).
- rd_ch  input  4  channel-word 0..15.
- rd_data  output  DATA_W  read data, registered.
- rd_data_vld  output  1  rd_data valid.
- err_flag  output  1  sticky error (see Configuration).

## Operation
- Storage: two banks of K3_WORDS+K1_WORDS words each.
- Index mapping: a 3x3 word goes to pos*16+ch. A 1x1 word goes to K3_WORDS+ch.
- Bank status: one bit per bank, EMPTY or FULL. Two pointers: wsel (write bank) and rsel (read bank).
- fill_rdy = status[wsel]==EMPTY.
- wbuf_vld = status[rsel]==FULL.
- wbuf_och = och_tag[rsel].
- Write path:
  - If weight_wen=1 and status[wsel]==EMPTY: write the word to bank wsel at the mapped index, and latch waddr[30:23] into och_tag[wsel].
  - If weight_wen=1 and status[wsel]==FULL: drop the write; storage is unchanged.
- Fill done: if weight_done=1 and status[wsel]==EMPTY, set status[wsel]<=FULL and toggle wsel. If status[wsel]==FULL, ignore the pulse.
- Release: if wbuf_release=1 and status[rsel]==FULL, set status[rsel]<=EMPTY and toggle rsel. If status[rsel]==EMPTY, ignore the pulse.
- Done and release in the same cycle:
  - With wsel!=rsel, both take effect.
  - With wsel==rsel, the bank is either EMPTY or FULL, so at most one of the two events is legal. Only the legal event takes effect.
- Read path:
  - If rd_en=1 and wbuf_vld=1: read bank rsel at the mapped index.
  - If rd_en=1 and wbuf_vld=0: rd_data_vld stays 0 and rd_data holds its previous value.
- A read of a bank released in the same cycle still returns the pre-release contents, because storage is not cleared.
- Write and read never target the same bank concurrently, so no read-after-write bypass is required.

## Timing
- Reset values:
  - status = {EMPTY, EMPTY}, wsel=0, rsel=0, och_tag=0.
  - Outputs: fill_rdy=1, wbuf_vld=0, wbuf_och=0, rd_data=0, rd_data_vld=0, err_flag=0.
  - Storage contents are not reset.
- Reset asserted mid-fill or mid-read: the cycle after rst_n is sampled low, both banks are EMPTY and any partial fill is discarded.
- Write: the word is stored at the clk edge where weight_wen=1. Throughput is 1 word/cycle.
- weight_done at edge N: fill_rdy and wbuf_vld are updated at edge N+1. The same cycle can accept a write to the new wsel bank.
- Read latency is 1 cycle: rd_en at edge N gives rd_data/rd_data_vld valid after edge N+1. rd_data_vld is a one-cycle pulse per accepted read. Reads are fully pipelined, one per cycle.
- wbuf_release at edge N: wbuf_vld reflects the new rsel bank after edge N+1.

## Configuration
- Macro WBUF_ERR_CHK_EN.
- Defined: a per-fill write counter (8-bit) is cleared on an accepted weight_done or on reset. err_flag sets and stays set until reset on any of:
  - a write dropped because the write bank is FULL;
  - an accepted weight_done with counter != 160;
  - rd_en while wbuf_vld=0;
  - a write with waddr[31]=0 and position > 8.
- Not defined: no counter or check logic is built; err_flag is tied to 0.

## Test plan
- Reset, then write 160 words with data = index, then weight_done. Required: fill_rdy=1, wbuf_vld=1, wbuf_och equals the written tag. Reading pos=8, ch=15 returns 143; reading 1x1 ch=3 returns 147; each with rd_data_vld one cycle after rd_en.
- Fill bank0 (och 5) and bank1 (och 6) back-to-back. Required: fill_rdy=0. A third stream's writes are dropped, and err_flag=1 when WBUF_ERR_CHK_EN is defined. After wbuf_release, wbuf_och=6 and fill_rdy=1.
- With bank0 FULL and bank1 filling, assert weight_done and wbuf_release in the same cycle. Required: next cycle wbuf_vld=1, wbuf_och = bank1 tag, fill_rdy=1.
- rd_en with wbuf_vld=0. Required: rd_data_vld stays 0 and rd_data is unchanged. Under WBUF_ERR_CHK_EN, err_flag=1.
- weight_done after only 100 writes. Required: the bank becomes FULL, and err_flag=1 only under WBUF_ERR_CHK_EN.
- Drop rst_n mid-fill (after 70 words). Required: the next cycle shows fill_rdy=1, wbuf_vld=0, err_flag=0, and a subsequent full fill behaves as in the first scenario.

Source files
------------

// File: rtl/weight_pingpong_buf.sv
// Ping-pong weight store: one bank fills from the weight bus while the MAC array reads the other.
// Optional checker logic is built when WBUF_ERR_CHK_EN is defined; otherwise err_flag is tied low.
module weight_pingpong_buf #(
    parameter int DATA_W   = 32,
    parameter int K3_WORDS = 144,
    parameter int K1_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       weight_waddr,
    input  logic [DATA_W-1:0] weight_wdata,
    input  logic              weight_wen,
    input  logic              weight_done,
    output logic              fill_rdy,
    output logic              wbuf_vld,
    output logic [7:0]        wbuf_och,
    input  logic              wbuf_release,
    input  logic              rd_en,
    input  logic              rd_1x1,
    input  logic [3:0]        rd_pos,
    input  logic [3:0]        rd_ch,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic              err_flag
);

    localparam int BANK_WORDS = K3_WORDS + K1_WORDS;
    localparam int IDX_W      = $clog2(BANK_WORDS);
    localparam logic [9:0] K3_BASE = 10'(K3_WORDS);

    // 3x3 words sit at pos*16+ch; 1x1 words follow the 3x3 region.
    function automatic logic [9:0] map_idx(input logic is_1x1, input logic [5:0] pos,
                                           input logic [3:0] ch);
        logic [9:0] idx;
        if (is_1x1) begin
            idx = K3_BASE + {6'd0, ch};
        end else begin
            idx = {pos, ch};
        end
        return idx;
    endfunction

    logic [DATA_W-1:0] mem_r [0:1][0:BANK_WORDS-1];
    logic [1:0]        status_r, status_s;
    logic              wsel_r, wsel_s, rsel_r, rsel_s;
    logic [1:0][7:0]   och_r, och_s;
    logic              fill_rdy_r, wbuf_vld_r;
    logic [7:0]        wbuf_och_r;
    logic [DATA_W-1:0] rd_data_r, rd_word_s;
    logic              rd_data_vld_r;
    logic [9:0]        widx_s, ridx_s;
    logic              wpos_ok_s, rpos_ok_s;
    logic              wr_acc_s, wr_store_s, done_acc_s, rel_acc_s, rd_acc_s;
    logic              unused_s;

    // Address decode and acceptance of write, done, release and read requests.
    always_comb begin
        widx_s     = map_idx(weight_waddr[31], weight_waddr[11:6], weight_waddr[3:0]);
        ridx_s     = map_idx(rd_1x1, {2'b00, rd_pos}, rd_ch);
        wpos_ok_s  = weight_waddr[31] | ({weight_waddr[11:6], 4'b0000} < K3_BASE);
        rpos_ok_s  = rd_1x1 | ({2'b00, rd_pos, 4'b0000} < K3_BASE);
        wr_acc_s   = weight_wen & ~status_r[wsel_r];
        wr_store_s = wr_acc_s & wpos_ok_s;
        done_acc_s = weight_done & ~status_r[wsel_r];
        rel_acc_s  = wbuf_release & status_r[rsel_r];
        rd_acc_s   = rd_en & status_r[rsel_r];
    end

    assign unused_s = ^{weight_waddr[22:12], weight_waddr[5:4], widx_s[9:IDX_W], ridx_s[9:IDX_W]};

    // Bank ownership: done fills the write bank, release frees the read bank.
    // When both pointers coincide only one of the two can be legal, so no arbitration is needed.
    always_comb begin
        status_s = status_r;
        wsel_s   = wsel_r;
        rsel_s   = rsel_r;
        och_s    = och_r;
        if (wr_acc_s) begin
            och_s[wsel_r] = weight_waddr[30:23];
        end else begin
            och_s = och_r;
        end
        if (done_acc_s) begin
            status_s[wsel_r] = 1'b1;
            wsel_s           = ~wsel_r;
        end else begin
            wsel_s = wsel_r;
        end
        if (rel_acc_s) begin
            status_s[rsel_r] = 1'b0;
            rsel_s           = ~rsel_r;
        end else begin
            rsel_s = rsel_r;
        end
    end

    // Control state and status outputs, registered from next-state values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_r   <= 2'b00;
            wsel_r     <= 1'b0;
            rsel_r     <= 1'b0;
            och_r      <= {2{8'h00}};
            fill_rdy_r <= 1'b1;
            wbuf_vld_r <= 1'b0;
            wbuf_och_r <= 8'h00;
        end else begin
            status_r   <= status_s;
            wsel_r     <= wsel_s;
            rsel_r     <= rsel_s;
            och_r      <= och_s;
            fill_rdy_r <= ~status_s[wsel_s];
            wbuf_vld_r <= status_s[rsel_s];
            wbuf_och_r <= och_s[rsel_s];
        end
    end

    // Weight storage; contents survive reset and are simply overwritten by the next fill.
    always_ff @(posedge clk) begin
        if (wr_store_s) begin
            mem_r[wsel_r][widx_s[IDX_W-1:0]] <= weight_wdata;
        end
    end

    // Out-of-range kernel positions read back as zero rather than aliasing into the 1x1 region.
    always_comb begin
        if (rpos_ok_s) begin
            rd_word_s = mem_r[rsel_r][ridx_s[IDX_W-1:0]];
        end else begin
            rd_word_s = {DATA_W{1'b0}};
        end
    end

    // Read pipeline: one-cycle latency, data held when no read is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_r     <= {DATA_W{1'b0}};
            rd_data_vld_r <= 1'b0;
        end else begin
            rd_data_vld_r <= rd_acc_s;
            if (rd_acc_s) begin
                rd_data_r <= rd_word_s;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

`ifdef WBUF_ERR_CHK_EN
    logic [7:0] wcnt_r;
    logic       err_r, err_evt_s;

    // Protocol violations that latch the sticky error.
    always_comb begin
        if (weight_wen & status_r[wsel_r]) begin
            err_evt_s = 1'b1;
        end else if (done_acc_s & (wcnt_r != 8'(BANK_WORDS))) begin
            err_evt_s = 1'b1;
        end else if (rd_en & ~status_r[rsel_r]) begin
            err_evt_s = 1'b1;
        end else if (weight_wen & ~wpos_ok_s) begin
            err_evt_s = 1'b1;
        end else begin
            err_evt_s = 1'b0;
        end
    end

    // Per-fill word counter and sticky error register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_r <= 8'd0;
            err_r  <= 1'b0;
        end else begin
            if (done_acc_s) begin
                wcnt_r <= 8'd0;
            end else if (wr_acc_s) begin
                wcnt_r <= wcnt_r + 8'd1;
            end else begin
                wcnt_r <= wcnt_r;
            end
            if (err_evt_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign err_flag = err_r;
`else
    assign err_flag = 1'b0;
`endif

    assign fill_rdy    = fill_rdy_r;
    assign wbuf_vld    = wbuf_vld_r;
    assign wbuf_och    = wbuf_och_r;
    assign rd_data     = rd_data_r;
    assign rd_data_vld = rd_data_vld_r;

endmodule

// File: tb/tb_weight_pingpong_buf.sv
// Self-checking bench for weight_pingpong_buf; read data is checked through an expected-value queue.
module tb_weight_pingpong_buf;

`ifdef WBUF_ERR_CHK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] weight_waddr;
    logic [31:0] weight_wdata;
    logic        weight_wen;
    logic        weight_done;
    logic        fill_rdy;
    logic        wbuf_vld;
    logic [7:0]  wbuf_och;
    logic        wbuf_release;
    logic        rd_en;
    logic        rd_1x1;
    logic [3:0]  rd_pos;
    logic [3:0]  rd_ch;
    logic [31:0] rd_data;
    logic        rd_data_vld;
    logic        err_flag;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    weight_pingpong_buf dut (
        .clk(clk), .rst_n(rst_n),
        .weight_waddr(weight_waddr), .weight_wdata(weight_wdata),
        .weight_wen(weight_wen), .weight_done(weight_done),
        .fill_rdy(fill_rdy), .wbuf_vld(wbuf_vld), .wbuf_och(wbuf_och),
        .wbuf_release(wbuf_release), .rd_en(rd_en), .rd_1x1(rd_1x1),
        .rd_pos(rd_pos), .rd_ch(rd_ch), .rd_data(rd_data),
        .rd_data_vld(rd_data_vld), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic is1x1, input logic [7:0] och, input int pos,
                              input int ch, input logic [31:0] d);
        weight_waddr = {is1x1, och, 11'd0, 6'(pos), 2'b00, 4'(ch)};
        weight_wdata = d;
        weight_wen   = 1'b1;
        tick();
        weight_wen   = 1'b0;
    endtask

    task automatic fill(input logic [7:0] och, input int nwords, input int base);
        for (int i = 0; i < nwords; i++) begin
            if (i < 144) write_word(1'b0, och, i / 16, i % 16, 32'(base + i));
            else         write_word(1'b1, och, 0, i - 144, 32'(base + i));
        end
    endtask

    task automatic pulse_done();
        weight_done = 1'b1;
        tick();
        weight_done = 1'b0;
    endtask

    task automatic pulse_release();
        wbuf_release = 1'b1;
        tick();
        wbuf_release = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_read(input string name, input logic is1x1, input int pos, input int ch,
                           input logic [31:0] exp);
        logic [31:0] e;
        rd_1x1 = is1x1;
        rd_pos = 4'(pos);
        rd_ch  = 4'(ch);
        rd_en  = 1'b1;
        exp_q.push_back(exp);
        tick();
        rd_en  = 1'b0;
        n_cmp++;
        if (rd_data_vld !== 1'b1) begin n_bad++; $display("FAIL %s_vld: got %b want 1", name, rd_data_vld); end
        e = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== e) begin n_bad++; $display("FAIL %s_data: got %0d want %0d", name, rd_data, e); end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (fill_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_fill_rdy: got %b want 1", fill_rdy); end
        n_cmp++; if (wbuf_vld !== 1'b0) begin n_bad++; $display("FAIL rst_wbuf_vld: got %b want 0", wbuf_vld); end
        n_cmp++; if (wbuf_och !== 8'h00) begin n_bad++; $display("FAIL rst_wbuf_och: got %h want 00", wbuf_och); end
        n_cmp++; if (rd_data !== 32'd0) begin n_bad++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
        n_cmp++; if (rd_data_vld !== 1'b0) begin n_bad++; $display("FAIL rst_rd_vld: got %b want 0", rd_data_vld); end
        n_cmp++; if (err_flag !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_flag); end
    endtask

    task automatic test_basic_fill(input logic [7:0] och);
        fill(och, 160, 0);
        n_cmp++; if (wbuf_vld !== 1'b0) begin n_bad++; $display("FAIL fill_pre_vld: got %b want 0", wbuf_vld); end
        pulse_done();
        n_cmp++; if (fill_rdy !== 1'b1) begin n_bad++; $display("FAIL fill_rdy: got %b want 1", fill_rdy); end
        n_cmp++; if (wbuf_vld !== 1'b1) begin n_bad++; $display("FAIL fill_vld: got %b want 1", wbuf_vld); end
        n_cmp++; if (wbuf_och !== och) begin n_bad++; $display("FAIL fill_och: got %h want %h", wbuf_och, och); end
        n_cmp++; if (err_flag !== 1'b0) begin n_bad++; $display("FAIL fill_err: got %b want 0", err_flag); end
        do_read("rd_p8c15", 1'b0, 8, 15, 32'd143);
        tick();
        n_cmp++; if (rd_data_vld !== 1'b0) begin n_bad++; $display("FAIL rd_vld_pulse: got %b want 0", rd_data_vld); end
        do_read("rd_1x1c3", 1'b1, 0, 3, 32'd147);
        do_read("rd_p0c0", 1'b0, 0, 0, 32'd0);
        do_read("rd_p3c7", 1'b0, 3, 7, 32'd55);
        do_read("rd_1x1c15", 1'b1, 0, 15, 32'd159);
        tick();
        n_cmp++; if (rd_data_vld !== 1'b0) begin n_bad++; $display("FAIL rd_burst_end: got %b want 0", rd_data_vld); end
    endtask

    task automatic test_back_to_back();
        fill(8'd5, 160, 1000);
        pulse_done();
        fill(8'd6, 160, 2000);
        pulse_done();
        n_cmp++; if (fill_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_fill_rdy: got %b want 0", fill_rdy); end
        n_cmp++; if (wbuf_och !== 8'd5) begin n_bad++; $display("FAIL b2b_och: got %0d want 5", wbuf_och); end
        fill(8'd7, 10, 9000);
        n_cmp++; if (err_flag !== ERR_EN) begin n_bad++; $display("FAIL b2b_drop_err: got %b want %b", err_flag, ERR_EN); end
        n_cmp++; if (wbuf_och !== 8'd5) begin n_bad++; $display("FAIL b2b_drop_och: got %0d want 5", wbuf_och); end
        do_read("b2b_rd_bank5", 1'b0, 0, 0, 32'd1000);
        pulse_release();
        n_cmp++; if (wbuf_och !== 8'd6) begin n_bad++; $display("FAIL b2b_rel_och: got %0d want 6", wbuf_och); end
        n_cmp++; if (fill_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_rel_fill_rdy: got %b want 1", fill_rdy); end
        n_cmp++; if (wbuf_vld !== 1'b1) begin n_bad++; $display("FAIL b2b_rel_vld: got %b want 1", wbuf_vld); end
        do_read("b2b_rd_bank6", 1'b0, 0, 5, 32'd2005);
    endtask

    task automatic test_same_cycle();
        fill(8'd9, 160, 3000);
        weight_done  = 1'b1;
        wbuf_release = 1'b1;
        tick();
        weight_done  = 1'b0;
        wbuf_release = 1'b0;
        n_cmp++; if (wbuf_vld !== 1'b1) begin n_bad++; $display("FAIL same_vld: got %b want 1", wbuf_vld); end
        n_cmp++; if (wbuf_och !== 8'd9) begin n_bad++; $display("FAIL same_och: got %0d want 9", wbuf_och); end
        n_cmp++; if (fill_rdy !== 1'b1) begin n_bad++; $display("FAIL same_fill_rdy: got %b want 1", fill_rdy); end
        do_read("same_rd", 1'b0, 1, 0, 32'd3016);
        pulse_release();
        pulse_release();
        n_cmp++; if (wbuf_vld !== 1'b0) begin n_bad++; $display("FAIL idle_rel_vld: got %b want 0", wbuf_vld); end
        n_cmp++; if (fill_rdy !== 1'b1) begin n_bad++; $display("FAIL idle_rel_fill_rdy: got %b want 1", fill_rdy); end
    endtask

    task automatic test_rd_empty();
        do_reset();
        fill(8'h03, 160, 500);
        pulse_done();
        do_read("rde_rd", 1'b0, 2, 1, 32'd533);
        n_cmp++; if (err_flag !== 1'b0) begin n_bad++; $display("FAIL rde_no_err: got %b want 0", err_flag); end
        pulse_release();
        rd_pos = 4'd0;
        rd_ch  = 4'd0;
        rd_en  = 1'b1;
        tick();
        rd_en  = 1'b0;
        n_cmp++; if (rd_data_vld !== 1'b0) begin n_bad++; $display("FAIL rde_vld: got %b want 0", rd_data_vld); end
        n_cmp++; if (rd_data !== 32'd533) begin n_bad++; $display("FAIL rde_hold: got %0d want 533", rd_data); end
        n_cmp++; if (err_flag !== ERR_EN) begin n_bad++; $display("FAIL rde_err: got %b want %b", err_flag, ERR_EN); end
    endtask

    task automatic test_short_fill();
        do_reset();
        fill(8'h44, 100, 700);
        pulse_done();
        n_cmp++; if (wbuf_vld !== 1'b1) begin n_bad++; $display("FAIL short_vld: got %b want 1", wbuf_vld); end
        n_cmp++; if (wbuf_och !== 8'h44) begin n_bad++; $display("FAIL short_och: got %h want 44", wbuf_och); end
        n_cmp++; if (err_flag !== ERR_EN) begin n_bad++; $display("FAIL short_err: got %b want %b", err_flag, ERR_EN); end
        do_read("short_rd", 1'b0, 6, 3, 32'd799);
    endtask

    task automatic test_reset_mid_fill();
        fill(8'h55, 70, 4000);
        rst_n = 1'b0;
        tick();
        n_cmp++; if (fill_rdy !== 1'b1) begin n_bad++; $display("FAIL mid_rst_fill_rdy: got %b want 1", fill_rdy); end
        n_cmp++; if (wbuf_vld !== 1'b0) begin n_bad++; $display("FAIL mid_rst_vld: got %b want 0", wbuf_vld); end
        n_cmp++; if (err_flag !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err: got %b want 0", err_flag); end
        rst_n = 1'b1;
        test_basic_fill(8'h11);
    endtask

    initial begin
        rst_n        = 1'b0;
        weight_waddr = 32'd0;
        weight_wdata = 32'd0;
        weight_wen   = 1'b0;
        weight_done  = 1'b0;
        wbuf_release = 1'b0;
        rd_en        = 1'b0;
        rd_1x1       = 1'b0;
        rd_pos       = 4'd0;
        rd_ch        = 4'd0;
        test_reset();
        test_basic_fill(8'h2A);
        pulse_release();
        test_back_to_back();
        test_same_cycle();
        test_rd_empty();
        test_short_fill();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
